// File: rtl/m6502_addr_sequencer.sv
// M6502 effective-address / memory-access sequencer: walks the bus cycles of each
// addressing mode, then performs the read, write or read-modify-write access.
package M6502Defs;
   typedef enum logic [3:0] {
      Implied, Immediate, ZeroPage, ZeroPageIndexed, Absolute, AbsoluteIndexed,
      IndexedIndirect, IndirectIndexed, Relative, AbsoluteIndirect
   } AddressingMode;
   typedef enum logic [1:0] {Read, Write, ReadWrite} AccessType;
   typedef enum logic [1:0] {IdxNone, IdxX, IdxY} Index;
endpackage

module m6502_addr_sequencer
   import M6502Defs::*;
(
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_start,
   input  AddressingMode i_addressingMode,
   input  AccessType     i_accessType,
   input  Index          i_index,
   input  logic [15:0]   i_pc,
   input  logic [7:0]    i_x,
   input  logic [7:0]    i_y,
   input  logic [7:0]    i_busData,
   input  logic [7:0]    i_result,
   input  logic          i_resultValid,
   output logic [15:0]   o_busAddr,
   output logic          o_busRw,
   output logic [7:0]    o_busData,
   output logic          o_pcInc,
   output logic [7:0]    o_operand,
   output logic          o_operandValid,
   output logic [15:0]   o_effAddr,
   output logic          o_busy,
   output logic          o_done
);
   typedef enum logic [3:0] {
      S_IDLE, S_OPLO, S_OPHI, S_ZPIDX, S_PTRLO, S_PTRHI, S_FIXUP, S_READ, S_RMWDUMMY, S_WRITE
   } state_e;

   state_e        state_q, state_d;
   AddressingMode mode_q, mode_d;
   AccessType     access_q, access_d;
   logic [15:0]   pc_q, pc_d, base_q, base_d, eff_q, eff_d, last_addr_q, last_addr_d;
   logic [7:0]    idx_q, idx_d, zp_q, zp_d, data_q, data_d, operand_q, operand_d;
   logic          op_valid_q, op_valid_d, done_q, done_d;

   logic [15:0]   bus_addr;
   logic [15:0]   ptr_full;
   logic [15:0]   idx_sum;
   logic          page_cross;
   state_e        access_state;

   // High byte arrives on the bus this cycle; low byte was captured earlier.
   assign ptr_full     = {i_busData, base_q[7:0]};
   assign idx_sum      = ptr_full + {8'h00, idx_q};
   assign page_cross   = (idx_sum[15:8] != i_busData);
   assign access_state = (access_q == Write) ? S_WRITE : S_READ;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
      state_d    = state_q;
      mode_d     = mode_q;
      access_d   = access_q;
      pc_d       = pc_q;
      idx_d      = idx_q;
      base_d     = base_q;
      zp_d       = zp_q;
      eff_d      = eff_q;
      data_d     = data_q;
      operand_d  = operand_q;
      op_valid_d = 1'b0;
      done_d     = 1'b0;
      bus_addr   = last_addr_q;
      o_busRw    = 1'b1;
      o_busData  = 8'h00;
      o_pcInc    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               state_d  = S_OPLO;
               mode_d   = i_addressingMode;
               access_d = i_accessType;
               pc_d     = i_pc;
               case (i_addressingMode)
                  IndexedIndirect: idx_d = i_x;
                  IndirectIndexed: idx_d = i_y;
                  default:         idx_d = (i_index == IdxX) ? i_x :
                                           (i_index == IdxY) ? i_y : 8'h00;
               endcase
            end
         end
         S_OPLO: begin
            bus_addr = pc_q;
            o_pcInc  = 1'b1;
            base_d   = {8'h00, i_busData};
            zp_d     = i_busData;
            case (mode_q)
               Immediate: begin
                  operand_d  = i_busData;
                  op_valid_d = 1'b1;
                  eff_d      = pc_q;
                  done_d     = 1'b1;
                  state_d    = S_IDLE;
               end
               ZeroPage: begin
                  eff_d   = {8'h00, i_busData};
                  state_d = access_state;
               end
               ZeroPageIndexed, IndexedIndirect: state_d = S_ZPIDX;
               Absolute, AbsoluteIndexed:        state_d = S_OPHI;
               IndirectIndexed:                  state_d = S_PTRLO;
               default: begin
                  // Implied/Relative/AbsoluteIndirect: a lone dummy read, no byte consumed.
                  o_pcInc = 1'b0;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            endcase
         end
         S_OPHI, S_PTRHI: begin
            bus_addr = (state_q == S_OPHI) ? pc_q + 16'd1 : {8'h00, zp_q + 8'h01};
            o_pcInc  = (state_q == S_OPHI);
            if (mode_q == Absolute || mode_q == IndexedIndirect) begin
               eff_d   = ptr_full;
               state_d = access_state;
            end else begin
               base_d  = ptr_full;
               eff_d   = idx_sum;
               state_d = (access_q == Read && !page_cross) ? access_state : S_FIXUP;
            end
         end
         S_ZPIDX: begin
            bus_addr = {8'h00, zp_q};
            zp_d     = zp_q + idx_q;
            if (mode_q == ZeroPageIndexed) begin
               eff_d   = {8'h00, zp_q + idx_q};
               state_d = access_state;
            end else begin
               state_d = S_PTRLO;
            end
         end
         S_PTRLO: begin
            bus_addr = {8'h00, zp_q};
            base_d   = {8'h00, i_busData};
            state_d  = S_PTRHI;
         end
         S_FIXUP: begin
            bus_addr = {base_q[15:8], eff_q[7:0]};
            state_d  = access_state;
         end
         S_READ: begin
            bus_addr   = eff_q;
            data_d     = i_busData;
            operand_d  = i_busData;
            op_valid_d = 1'b1;
            if (access_q == ReadWrite) begin
               state_d = S_RMWDUMMY;
            end else begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_RMWDUMMY: begin
            bus_addr  = eff_q;
            o_busRw   = 1'b0;
            o_busData = data_q;
            state_d   = S_WRITE;
         end
         S_WRITE: begin
            bus_addr  = eff_q;
            o_busData = i_result;
            if (i_resultValid) begin
               o_busRw = 1'b0;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      last_addr_d = bus_addr;
   end

   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (i_reset) begin
         state_q     <= S_IDLE;
         mode_q      <= Implied;
         access_q    <= Read;
         pc_q        <= 16'h0000;
         idx_q       <= 8'h00;
         base_q      <= 16'h0000;
         zp_q        <= 8'h00;
         eff_q       <= 16'h0000;
         last_addr_q <= 16'h0000;
         data_q      <= 8'h00;
         operand_q   <= 8'h00;
         op_valid_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         access_q    <= access_d;
         pc_q        <= pc_d;
         idx_q       <= idx_d;
         base_q      <= base_d;
         zp_q        <= zp_d;
         eff_q       <= eff_d;
         last_addr_q <= last_addr_d;
         data_q      <= data_d;
         operand_q   <= operand_d;
         op_valid_q  <= op_valid_d;
         done_q      <= done_d;
      end
   end

   assign o_busAddr      = bus_addr;
   assign o_operand      = operand_q;
   assign o_operandValid = op_valid_q;
   assign o_effAddr      = eff_q;
   assign o_busy         = (state_q != S_IDLE);
   assign o_done         = done_q;

endmodule

// File: tb/tb_m6502_addr_sequencer.sv
// Directed bench for m6502_addr_sequencer: a byte-array memory answers reads and each
// sequence's bus trace is compared against hand-derived cycle lists.
module tb_m6502_addr_sequencer;
   import M6502Defs::*;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   AddressingMode mode;
   AccessType     access;
   Index          index;
   logic [15:0]   pc;
   logic [7:0]    x, y, bus_rdata, result;
   logic          result_valid;
   logic [15:0]   bus_addr, eff_addr;
   logic          bus_rw, pc_inc, operand_valid, busy, done;
   logic [7:0]    bus_wdata, operand;

   logic [7:0]    mem [0:65535];

   int            tests_run = 0;
   int            tests_failed = 0;

   logic [15:0]   tr_addr[$], ex_addr[$];
   logic          tr_rw[$], ex_rw[$];
   logic [7:0]    tr_data[$], ex_data[$];
   int            done_cycle, pcinc_count, opvalid_count;
   logic [7:0]    op_seen;
   logic [15:0]   idle_addr;
   logic          idle_rw;
   logic          saw_write;

   always #5 clk = ~clk;

   assign bus_rdata = mem[bus_addr];

   m6502_addr_sequencer dut (
      .i_clk            (clk),
      .i_reset          (reset),
      .i_start          (start),
      .i_addressingMode (mode),
      .i_accessType     (access),
      .i_index          (index),
      .i_pc             (pc),
      .i_x              (x),
      .i_y              (y),
      .i_busData        (bus_rdata),
      .i_result         (result),
      .i_resultValid    (result_valid),
      .o_busAddr        (bus_addr),
      .o_busRw          (bus_rw),
      .o_busData        (bus_wdata),
      .o_pcInc          (pc_inc),
      .o_operand        (operand),
      .o_operandValid   (operand_valid),
      .o_effAddr        (eff_addr),
      .o_busy           (busy),
      .o_done           (done)
   );

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic expect_cycle(input logic [15:0] a, input logic rw, input logic [7:0] d);
      ex_addr.push_back(a);
      ex_rw.push_back(rw);
      ex_data.push_back(d);
   endtask

   // Launch one sequence; cycle 1 is the first bus cycle. result_valid is low before cycle rv_from.
   task automatic run_seq(input AddressingMode m, input AccessType acc, input Index idx,
                          input logic [15:0] p, input logic [7:0] xv, input logic [7:0] yv,
                          input logic [7:0] res, input int rv_from);
      int cyc;
      bit seen_done;
      @(negedge clk);
      start = 1'b1; mode = m; access = acc; index = idx; pc = p; x = xv; y = yv; result = res;
      @(negedge clk);
      start = 1'b0;
      tr_addr.delete(); tr_rw.delete(); tr_data.delete();
      cyc = 0; seen_done = 0; done_cycle = -1; pcinc_count = 0; opvalid_count = 0;
      op_seen = 8'h00; idle_addr = 16'h0000; idle_rw = 1'b0;
      while (!seen_done && cyc < 50) begin
         cyc++;
         result_valid = (cyc >= rv_from);
         #1;
         if (busy) begin
            tr_addr.push_back(bus_addr);
            tr_rw.push_back(bus_rw);
            tr_data.push_back(bus_wdata);
         end
         if (pc_inc) pcinc_count++;
         if (operand_valid) begin
            opvalid_count++;
            op_seen = operand;
         end
         if (done) begin
            seen_done  = 1;
            done_cycle = cyc;
            idle_addr  = bus_addr;
            idle_rw    = bus_rw;
         end else begin
            @(negedge clk);
         end
      end
      result_valid = 1'b1;
   endtask

   task automatic compare_trace(input string tag, input int exp_done, input int exp_pcinc,
                                input int exp_opvalid);
      check({tag, "_len"}, tr_addr.size(), ex_addr.size());
      for (int i = 0; i < ex_addr.size() && i < tr_addr.size(); i++) begin
         check($sformatf("%s_addr%0d", tag, i), tr_addr[i], ex_addr[i]);
         check($sformatf("%s_rw%0d", tag, i), tr_rw[i], ex_rw[i]);
         if (ex_rw[i] == 1'b0) check($sformatf("%s_wdata%0d", tag, i), tr_data[i], ex_data[i]);
      end
      check({tag, "_done_cycle"}, done_cycle, exp_done);
      check({tag, "_pcinc"}, pcinc_count, exp_pcinc);
      check({tag, "_opvalid"}, opvalid_count, exp_opvalid);
      if (ex_addr.size() > 0) check({tag, "_idle_addr"}, idle_addr, ex_addr[ex_addr.size() - 1]);
      check({tag, "_idle_rw"}, idle_rw, 1'b1);
      ex_addr.delete(); ex_rw.delete(); ex_data.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_addr"}, bus_addr, 16'h0000);
      check({tag, "_rw"}, bus_rw, 1'b1);
      check({tag, "_wdata"}, bus_wdata, 8'h00);
      check({tag, "_operand"}, operand, 8'h00);
      check({tag, "_eff"}, eff_addr, 16'h0000);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_done"}, done, 1'b0);
      check({tag, "_opvalid"}, operand_valid, 1'b0);
      check({tag, "_pcinc"}, pc_inc, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      reset = 1'b1; start = 1'b0; mode = Implied; access = Read; index = IdxNone;
      pc = 16'h0000; x = 8'h00; y = 8'h00; result = 8'h00; result_valid = 1'b1;
      repeat (3) @(negedge clk);
      #1 check_reset_outputs("reset");
      reset = 1'b0;

      // Read AbsoluteIndexed with page cross: $12F0 + $20 = $1310.
      mem[16'h0200] = 8'hF0; mem[16'h0201] = 8'h12; mem[16'h1310] = 8'h77;
      expect_cycle(16'h0200, 1'b1, 8'h00);
      expect_cycle(16'h0201, 1'b1, 8'h00);
      expect_cycle(16'h1210, 1'b1, 8'h00);
      expect_cycle(16'h1310, 1'b1, 8'h00);
      run_seq(AbsoluteIndexed, Read, IdxX, 16'h0200, 8'h20, 8'h00, 8'h00, 0);
      compare_trace("absx_rd", 5, 2, 1);
      check("absx_rd_operand", op_seen, 8'h77);
      check("absx_rd_eff", eff_addr, 16'h1310);

      // ReadWrite ZeroPageIndexed: ($80 + $90) mod 256 = $10.
      mem[16'h0400] = 8'h80; mem[16'h0010] = 8'h3C;
      expect_cycle(16'h0400, 1'b1, 8'h00);
      expect_cycle(16'h0080, 1'b1, 8'h00);
      expect_cycle(16'h0010, 1'b1, 8'h00);
      expect_cycle(16'h0010, 1'b0, 8'h3C);
      expect_cycle(16'h0010, 1'b0, 8'h3D);
      run_seq(ZeroPageIndexed, ReadWrite, IdxX, 16'h0400, 8'h90, 8'h00, 8'h3D, 0);
      compare_trace("zpx_rmw", 6, 1, 1);
      check("zpx_rmw_operand", op_seen, 8'h3C);
      check("zpx_rmw_eff", eff_addr, 16'h0010);

      // Read IndirectIndexed, pointer high byte wraps to $0000: $20FE + 3 = $2101.
      mem[16'h0500] = 8'hFF; mem[16'h00FF] = 8'hFE; mem[16'h0000] = 8'h20; mem[16'h2101] = 8'h5A;
      expect_cycle(16'h0500, 1'b1, 8'h00);
      expect_cycle(16'h00FF, 1'b1, 8'h00);
      expect_cycle(16'h0000, 1'b1, 8'h00);
      expect_cycle(16'h2001, 1'b1, 8'h00);
      expect_cycle(16'h2101, 1'b1, 8'h00);
      run_seq(IndirectIndexed, Read, IdxY, 16'h0500, 8'h00, 8'h03, 8'h00, 0);
      compare_trace("indy_rd", 6, 1, 1);
      check("indy_rd_operand", op_seen, 8'h5A);
      check("indy_rd_eff", eff_addr, 16'h2101);

      // Write AbsoluteIndexed without page cross still issues the fixup read.
      mem[16'h0300] = 8'h00; mem[16'h0301] = 8'h30;
      expect_cycle(16'h0300, 1'b1, 8'h00);
      expect_cycle(16'h0301, 1'b1, 8'h00);
      expect_cycle(16'h3005, 1'b1, 8'h00);
      expect_cycle(16'h3005, 1'b0, 8'hA5);
      run_seq(AbsoluteIndexed, Write, IdxY, 16'h0300, 8'h00, 8'h05, 8'hA5, 0);
      compare_trace("absy_wr", 5, 2, 0);
      check("absy_wr_eff", eff_addr, 16'h3005);

      // Write ZeroPage with result held off for three WRITE cycles.
      mem[16'h0600] = 8'h44;
      expect_cycle(16'h0600, 1'b1, 8'h00);
      expect_cycle(16'h0044, 1'b1, 8'h00);
      expect_cycle(16'h0044, 1'b1, 8'h00);
      expect_cycle(16'h0044, 1'b1, 8'h00);
      expect_cycle(16'h0044, 1'b0, 8'hC3);
      run_seq(ZeroPage, Write, IdxNone, 16'h0600, 8'h00, 8'h00, 8'hC3, 5);
      compare_trace("zp_stall", 6, 1, 0);

      // Read AbsoluteIndexed without page cross skips the fixup.
      mem[16'h0700] = 8'h10; mem[16'h0701] = 8'h40; mem[16'h4015] = 8'hE7;
      expect_cycle(16'h0700, 1'b1, 8'h00);
      expect_cycle(16'h0701, 1'b1, 8'h00);
      expect_cycle(16'h4015, 1'b1, 8'h00);
      run_seq(AbsoluteIndexed, Read, IdxX, 16'h0700, 8'h05, 8'h00, 8'h00, 0);
      compare_trace("absx_nocross", 4, 2, 1);
      check("absx_nocross_operand", op_seen, 8'hE7);

      // Effective address wraps past $FFFF: $FFF0 + $20 = $0010.
      mem[16'h0800] = 8'hF0; mem[16'h0801] = 8'hFF;
      expect_cycle(16'h0800, 1'b1, 8'h00);
      expect_cycle(16'h0801, 1'b1, 8'h00);
      expect_cycle(16'hFF10, 1'b1, 8'h00);
      expect_cycle(16'h0010, 1'b1, 8'h00);
      run_seq(AbsoluteIndexed, Read, IdxX, 16'h0800, 8'h20, 8'h00, 8'h00, 0);
      compare_trace("absx_wrap", 5, 2, 1);
      check("absx_wrap_eff", eff_addr, 16'h0010);
      check("absx_wrap_operand", op_seen, 8'h3C);

      mem[16'h0900] = 8'h99;
      expect_cycle(16'h0900, 1'b1, 8'h00);
      run_seq(Immediate, Read, IdxNone, 16'h0900, 8'h00, 8'h00, 8'h00, 0);
      compare_trace("imm", 2, 1, 1);
      check("imm_operand", op_seen, 8'h99);

      expect_cycle(16'h0A00, 1'b1, 8'h00);
      run_seq(Implied, Read, IdxNone, 16'h0A00, 8'h00, 8'h00, 8'h00, 0);
      compare_trace("implied", 2, 0, 0);

      // Read IndexedIndirect: zp ($F0 + $14) mod 256 = $04, pointer $1234.
      mem[16'h0B00] = 8'hF0; mem[16'h0004] = 8'h34; mem[16'h0005] = 8'h12; mem[16'h1234] = 8'hAB;
      expect_cycle(16'h0B00, 1'b1, 8'h00);
      expect_cycle(16'h00F0, 1'b1, 8'h00);
      expect_cycle(16'h0004, 1'b1, 8'h00);
      expect_cycle(16'h0005, 1'b1, 8'h00);
      expect_cycle(16'h1234, 1'b1, 8'h00);
      run_seq(IndexedIndirect, Read, IdxX, 16'h0B00, 8'h14, 8'h00, 8'h00, 0);
      compare_trace("indx_rd", 6, 1, 1);
      check("indx_rd_operand", op_seen, 8'hAB);
      check("indx_rd_eff", eff_addr, 16'h1234);

      // Reset during PTRHI of a Write IndexedIndirect: abort with no write ever driven.
      @(negedge clk);
      start = 1'b1; mode = IndexedIndirect; access = Write; index = IdxX;
      pc = 16'h0B00; x = 8'h14; result = 8'h55;
      @(negedge clk);
      start = 1'b0;
      saw_write = 1'b0;
      repeat (3) begin
         #1 if (!bus_rw) saw_write = 1'b1;
         @(negedge clk);
      end
      #1 check("rst_ptrhi_addr", bus_addr, 16'h0005);
      check("rst_ptrhi_busy", busy, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1 check_reset_outputs("rst_abort");
      repeat (6) begin
         @(negedge clk);
         #1 if (!bus_rw) saw_write = 1'b1;
      end
      check("rst_no_write", saw_write, 1'b0);
      check("rst_idle_busy", busy, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
